btn_nav_conditioner: RTL
========================

Name: btn_nav_conditioner

Overview:
- Produces the navigation strobes consumed by the level-select cursor and the menu logic: clean single-cycle btn_up / btn_down / btn_sel pulses from raw Nexys4 pushbuttons.
- Chain per button: 2-flop synchronizer, debounce, press-edge pulse, then optional hold-to-auto-repeat.
- Sits between board pins and every menu/cursor block; a menu move happens exactly once per physical press or repeat tick.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable-level clocks required to accept a press or a release (10 ms at 100 MHz).
- HOLD_CYCLES, 50000000, clocks a press must be held before the first auto-repeat (500 ms).
- REPEAT_CYCLES, 15000000, clocks between successive auto-repeat pulses (150 ms).
- CNT_W, 26, counter width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset (clk and reset are the only clock and reset).
- enable  in  1  1 = pulses delivered; 0 = pulses masked, FSMs keep running.
- btn_up_raw  in  1  raw up button, asynchronous, bouncy.
- btn_down_raw  in  1  raw down button.
- btn_sel_raw  in  1  raw select button.
- btn_up  out  1  registered one-cycle up strobe.
- btn_down  out  1  registered one-cycle down strobe.
- btn_sel  out  1  registered one-cycle select strobe, never auto-repeats.
- any_held  out  1  registered; 1 while any channel is in HELD or REPEAT.

Behaviour:
- Reset (reset=0): all synchronizer flops, counters and pulse registers clear at once. FSMs go to IDLE. All outputs are 0 while reset is low and on the first edge after release.
- Synchronizer: two flops per input. A raw level sampled at edge N is visible to the FSM at edge N+2.
- Per-channel FSM (s = synchronized level, cnt = CNT_W counter):
  - IDLE: s=1 goes to DB_PRESS with cnt=0.
  - DB_PRESS: s=0 goes back to IDLE with no pulse. When s=1 and cnt==DEBOUNCE_CYCLES-1, go to HELD, cnt=0, fire a press pulse. Otherwise cnt+1.
  - HELD: s=0 goes to DB_RELEASE (cnt=0, remember HELD). If REPEAT_EN and cnt==HOLD_CYCLES-1, go to REPEAT, cnt=0, fire a pulse. Otherwise cnt+1.
  - REPEAT: s=0 goes to DB_RELEASE (remember REPEAT). When cnt==REPEAT_CYCLES-1, fire a pulse and set cnt=0. Otherwise cnt+1.
  - DB_RELEASE: s=1 returns to HELD with cnt=0 and no pulse (a release bounce never re-fires). When s=0 and cnt==DEBOUNCE_CYCLES-1, go to IDLE with no pulse. Otherwise cnt+1.
- Press latency: the first edge sampling raw high is edge 0. The pulse output is high for exactly one clock after edge DEBOUNCE_CYCLES+2.
- Repeat timing: repeat pulses follow the press pulse at +HOLD_CYCLES, then every +REPEAT_CYCLES.
- Counters never wrap; each compare resets its counter.
- Up/down interlock (top level): if up and down pulses occur in the same cycle, both are dropped. While both channels are in HELD/REPEAT, all their pulses are dropped. Sel is independent of the interlock.
- Final gating: btn_x = pulse & enable, registered. This adds 1 clock of latency, and the latency figure above already includes it.
- An enable toggle mid-hold does not reset any FSM state.

Decomposition:
- Shared package holds:
  - channel state encoding: IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE (3-bit);
  - default timing constants for 100 MHz;
  - a reduced sim constant set: DEBOUNCE=4, HOLD=20, REPEAT=8.
- Sub-module btn_debounce_channel (parameter REPEAT_EN) is instantiated three times, with REPEAT_EN=0 for sel.
- The top level holds only the interlock, enable gating, output registers and any_held.

Test Plan (sim params DEBOUNCE=4, HOLD=20, REPEAT=8; edge 0 = first edge sampling raw high):
- Reset: hold reset=0 with all raw inputs toggling -> every output is 0 and stays 0 for 2 clocks after reset rises.
- Clean up press held 10 clocks -> exactly one btn_up high cycle, after edge 6; btn_down and btn_sel stay 0; no pulse on release.
- Bounce: up_raw toggles 1,0,1,0 at 2-clock intervals, then stays high 12 clocks -> exactly one pulse, 6 edges after the final rising sample.
- Auto-repeat: down held for 60 clocks -> btn_down pulses after edges 6, 26, 34, 42, 50, 58; any_held is high through the hold; no pulse after release.
- Interlock and sel: up and down pressed together for 40 clocks -> zero up/down pulses. Sel held for 60 clocks -> one btn_sel pulse only. enable=0 during a press -> no pulse.
- Reset mid-REPEAT: assert reset at edge 30 of a down hold -> btn_down falls to 0 immediately. After reset release with the button still held, a new pulse occurs only after a fresh DEBOUNCE+2 edges.

Source files
------------

// File: rtl/btn_nav_conditioner_pkg.sv
// Shared types and constants for the navigation button conditioner.
package btn_nav_conditioner_pkg;

  // Per-channel debounce / hold / repeat state.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DB_PRESS   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_DB_RELEASE = 3'd4
  } chan_state_t;

  // What a channel reports to the top level each cycle.
  //   pulse : fire condition at the coming edge (registered by the top)
  //   held  : channel currently in HELD or REPEAT
  typedef struct packed {
    logic pulse;
    logic held;
  } chan_stat_t;

  // Channel indices inside the packed per-channel vectors.
  localparam int NUM_CH  = 3;
  localparam int CH_UP   = 0;
  localparam int CH_DOWN = 1;
  localparam int CH_SEL  = 2;

  // Board timing at 100 MHz.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;  // 10 ms
  localparam int unsigned DEF_HOLD_CYCLES     = 50000000; // 500 ms
  localparam int unsigned DEF_REPEAT_CYCLES   = 15000000; // 150 ms
  localparam int unsigned DEF_CNT_W           = 26;

  // Shortened timing for simulation.
  localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;
  localparam int unsigned SIM_HOLD_CYCLES     = 20;
  localparam int unsigned SIM_REPEAT_CYCLES   = 8;

  // True for the states where the button counts as held down.
  function automatic logic is_held(input chan_state_t st);
    return (st == ST_HELD) || (st == ST_REPEAT);
  endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-flop synchronizer, debounce FSM, press/repeat fire decode.
module btn_debounce_channel
  import btn_nav_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw,
  output chan_stat_t stat
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [1:0]       sync;
  logic             s;
  chan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             fire;

  // Two-stage synchronizer; raw sampled at edge N reaches the FSM at edge N+2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[0], raw};
  end

  assign s = sync[1];

  // Debounce / hold / repeat sequencing. Every compare that matches clears
  // the counter, so it never runs past its largest limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s) begin
            state <= ST_DB_PRESS;
            cnt   <= '0;
          end
        end
        ST_DB_PRESS: begin
          if (!s) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (!s) begin
            state <= ST_DB_RELEASE;
            cnt   <= '0;
          end else if (REPEAT_EN) begin
            if (cnt == HOLD_LAST) begin
              state <= ST_REPEAT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          // Without repeat the counter parks at zero while held.
        end
        ST_REPEAT: begin
          if (!s) begin
            state <= ST_DB_RELEASE;
            cnt   <= '0;
          end else if (cnt == REP_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DB_RELEASE: begin
          // A bounce during release goes back to HELD and restarts the hold
          // timer; it never produces a pulse.
          if (s) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Fire decode for the coming edge. It is flopped by the top's output
  // register, which lands the strobe in the same cycle the FSM moves on.
  always_comb begin
    fire = 1'b0;
    if (s) begin
      case (state)
        ST_DB_PRESS: fire = (cnt == DB_LAST);
        ST_HELD:     fire = REPEAT_EN && (cnt == HOLD_LAST);
        ST_REPEAT:   fire = REPEAT_EN && (cnt == REP_LAST);
        default:     fire = 1'b0;
      endcase
    end
  end

  assign stat.pulse = fire;
  assign stat.held  = is_held(state);

endmodule

// File: rtl/btn_nav_conditioner.sv
// Navigation strobes for the menu/cursor logic: three debounced channels,
// up/down interlock, enable gating and registered outputs.
module btn_nav_conditioner
  import btn_nav_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  input  logic btn_sel_raw,
  output logic btn_up,
  output logic btn_down,
  output logic btn_sel,
  output logic any_held
);

  logic [NUM_CH-1:0]       raw_vec;
  chan_stat_t [NUM_CH-1:0] stat;
  logic [NUM_CH-1:0]       pulse;
  logic [NUM_CH-1:0]       held;
  logic                    ud_drop;

  assign raw_vec = {btn_sel_raw, btn_down_raw, btn_up_raw};

  // Select never auto-repeats; up and down do.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_EN       (i != CH_SEL)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_vec[i]),
      .stat  (stat[i])
    );
  end

  // Unpack channel status into plain vectors.
  always_comb begin
    pulse = '0;
    held  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pulse[i] = stat[i].pulse;
      held[i]  = stat[i].held;
    end
  end

  // Conflicting up/down: a simultaneous pair, or both being held, moves nothing.
  assign ud_drop = (pulse[CH_UP] & pulse[CH_DOWN]) | (held[CH_UP] & held[CH_DOWN]);

  // Output strobes and held flag; enable only masks, the channels keep running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_up   <= 1'b0;
      btn_down <= 1'b0;
      btn_sel  <= 1'b0;
      any_held <= 1'b0;
    end else begin
      btn_up   <= enable & pulse[CH_UP]   & ~ud_drop;
      btn_down <= enable & pulse[CH_DOWN] & ~ud_drop;
      btn_sel  <= enable & pulse[CH_SEL];
      any_held <= |held;
    end
  end

endmodule
